// File: rtl/mips_pkg.sv
// Shared register-file write types: address/data widths, arbiter states and the
// write-request bundle passed between the arbiter and its priority selector.
package mips_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        MEM_PRI   = 1'b0,
        FORCE_ALU = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wr_req_t;
endpackage

// File: rtl/rf_wr_prio_sel.sv
// Combinational grant selector: loads win by default, the ALU wins while forced.
// Grants depend only on the valids and the arbiter state, never on data.
module rf_wr_prio_sel
    import mips_pkg::*;
(
    input  arb_state_e state,
    input  logic       alu_valid,
    input  logic       mem_valid,
    input  wr_req_t    alu_req,
    input  wr_req_t    mem_req,
    output logic       alu_grant,
    output logic       mem_grant,
    output wr_req_t    sel
);
    logic force_alu;

    always_comb begin
        // A forced state with no ALU request falls back to normal load priority.
        force_alu = (state == FORCE_ALU) && alu_valid;
        mem_grant = mem_valid && !force_alu;
        alu_grant = alu_valid && !mem_grant;
        sel       = mem_grant ? mem_req : alu_req;
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the register file's single write port between ALU and load writeback,
// with a starvation counter that forces an ALU grant after MAX_WAIT denials.
module rf_write_arbiter
    import mips_pkg::*;
#(
    parameter int MAX_WAIT = 3,
    parameter int CNT_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_addr,
    input  logic [REG_DATA_W-1:0] alu_data,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_addr,
    input  logic [REG_DATA_W-1:0] mem_data,
    output logic                  mem_ready,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_addr,
    output logic [REG_DATA_W-1:0] rf_data,
    output logic [NUM_REGS-1:0]   pending,
    output logic [CNT_W-1:0]      starve_cnt
);
    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

    arb_state_e       state;
    wr_req_t          alu_req, mem_req, sel;
    logic             alu_grant, mem_grant, transfer;
    logic [CNT_W-1:0] cnt_inc;

    assign alu_req = '{addr: alu_addr, data: alu_data};
    assign mem_req = '{addr: mem_addr, data: mem_data};

    rf_wr_prio_sel u_sel (
        .state     (state),
        .alu_valid (alu_valid),
        .mem_valid (mem_valid),
        .alu_req   (alu_req),
        .mem_req   (mem_req),
        .alu_grant (alu_grant),
        .mem_grant (mem_grant),
        .sel       (sel)
    );

    // Readies are held low while reset is asserted.
    assign alu_ready = alu_grant && rst_n;
    assign mem_ready = mem_grant && rst_n;
    assign transfer  = alu_grant || mem_grant;
    assign cnt_inc   = (starve_cnt >= WAIT_LIM) ? starve_cnt : starve_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= MEM_PRI;
            starve_cnt <= '0;
        end else if (state == FORCE_ALU) begin
            // One forced slot only; a dropped ALU request also ends it.
            state      <= MEM_PRI;
            starve_cnt <= '0;
        end else if (alu_valid && !alu_grant) begin
            starve_cnt <= cnt_inc;
            if (cnt_inc == WAIT_LIM)
                state <= FORCE_ALU;
        end else begin
            starve_cnt <= '0;
        end
    end

    // Writes to $0 are accepted but never reach the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we   <= 1'b0;
            rf_addr <= '0;
            rf_data <= '0;
        end else begin
            rf_we <= transfer && (sel.addr != '0);
            if (transfer) begin
                rf_addr <= sel.addr;
                rf_data <= sel.data;
            end
        end
    end

    always_comb begin
        pending = '0;
        if (rf_we)
            pending[rf_addr] = 1'b1;
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a small register-file model on rf_*.
module tb_rf_write_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, mem_valid;
    logic [4:0]  alu_addr, mem_addr;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [31:0] pending;
    logic [3:0]  starve_cnt;
    logic [31:0] regs [32];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rf_write_arbiter #(.MAX_WAIT(3), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
        .pending(pending), .starve_cnt(starve_cnt)
    );

    // Register file model: r0 hardwired to zero.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) regs[r] <= '0;
        end else if (rf_we && rf_addr != 5'd0) begin
            regs[rf_addr] <= rf_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h11;
        mem_valid = 1'b1; mem_addr = 5'd2; mem_data = 32'h22;
        #2;
        chk("rst_alu_ready", 32'(alu_ready), 32'd0);
        chk("rst_mem_ready", 32'(mem_ready), 32'd0);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_pending", pending, 32'd0);
        chk("rst_starve", 32'(starve_cnt), 32'd0);
        tick();
        rst_n = 1'b1;

        // Contention: mem, mem, mem, alu repeating
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("cont_mem_ready", 32'(mem_ready), (i % 4 == 3) ? 32'd0 : 32'd1);
            chk("cont_alu_ready", 32'(alu_ready), (i % 4 == 3) ? 32'd1 : 32'd0);
            tick();
            chk("cont_starve", 32'(starve_cnt), (i % 4 == 3) ? 32'd0 : 32'(i % 4 + 1));
            chk("cont_rf_addr", 32'(rf_addr), (i % 4 == 3) ? 32'd1 : 32'd2);
            chk("cont_rf_data", rf_data, (i % 4 == 3) ? 32'h11 : 32'h22);
            chk("cont_pending", pending, (i % 4 == 3) ? 32'h2 : 32'h4);
        end

        // Mid-stream asynchronous reset
        chk("pre_rst_we", 32'(rf_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", 32'(rf_we), 32'd0);
        chk("mid_rst_pending", pending, 32'd0);
        chk("mid_rst_alu_ready", 32'(alu_ready), 32'd0);
        chk("mid_rst_mem_ready", 32'(mem_ready), 32'd0);
        chk("mid_rst_addr", 32'(rf_addr), 32'd0);
        alu_valid = 1'b0; mem_valid = 1'b0;
        tick();
        rst_n = 1'b1;

        // Single ALU write
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        chk("alu_ready", 32'(alu_ready), 32'd1);
        chk("alu_mem_ready", 32'(mem_ready), 32'd0);
        tick();
        alu_valid = 1'b0;
        chk("alu_rf_we", 32'(rf_we), 32'd1);
        chk("alu_rf_addr", 32'(rf_addr), 32'd5);
        chk("alu_rf_data", rf_data, 32'hDEADBEEF);
        chk("alu_pending", pending, 32'h20);
        tick();
        chk("alu_r5", regs[5], 32'hDEADBEEF);
        chk("idle_rf_we", 32'(rf_we), 32'd0);
        chk("idle_rf_addr_hold", 32'(rf_addr), 32'd5);
        chk("idle_rf_data_hold", rf_data, 32'hDEADBEEF);

        // Write to $0
        mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'h1234;
        #1;
        chk("r0_mem_ready", 32'(mem_ready), 32'd1);
        tick();
        mem_valid = 1'b0;
        chk("r0_rf_we", 32'(rf_we), 32'd0);
        chk("r0_pending", pending, 32'd0);
        tick();
        chk("r0_value", regs[0], 32'd0);

        // Same destination: mem first, ALU overwrites
        mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'hA;
        alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'hB;
        #1;
        chk("same_mem_ready", 32'(mem_ready), 32'd1);
        chk("same_alu_ready0", 32'(alu_ready), 32'd0);
        tick();
        mem_valid = 1'b0;
        chk("same_rf_data0", rf_data, 32'hA);
        #1;
        chk("same_alu_ready1", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        chk("same_rf_data1", rf_data, 32'hB);
        chk("same_r7_mid", regs[7], 32'hA);
        tick();
        chk("same_r7_final", regs[7], 32'hB);

        // Bubble: ALU drops while forced
        mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 32'h33;
        alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h44;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bub_starve", 32'(starve_cnt), 32'(i + 1));
        end
        alu_valid = 1'b0;
        #1;
        chk("bub_mem_ready", 32'(mem_ready), 32'd1);
        chk("bub_alu_ready", 32'(alu_ready), 32'd0);
        tick();
        chk("bub_starve_clr", 32'(starve_cnt), 32'd0);
        chk("bub_rf_addr", 32'(rf_addr), 32'd3);
        alu_valid = 1'b1;
        #1;
        chk("bub_back_mem_ready", 32'(mem_ready), 32'd1);
        chk("bub_back_alu_ready", 32'(alu_ready), 32'd0);
        tick();
        chk("bub_back_starve", 32'(starve_cnt), 32'd1);
        alu_valid = 1'b0; mem_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
